// File: rtl/systolic_ctrl.sv
// Job sequencer for the systolic array: fetches A/B operands from the scratchpad,
// clears and runs the array, then writes the N result lanes back.

module systolic_ctrl_lane #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          a_we,
  input  logic          b_we,
  input  logic          p_we,
  input  logic [DW-1:0] d,
  input  logic [DW-1:0] p_in,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [DW-1:0] p
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a <= '0;
      b <= '0;
      p <= '0;
    end else begin
      if (clr) begin
        a <= '0;
        b <= '0;
      end else begin
        if (a_we) a <= d;
        if (b_we) b <= d;
      end
      if (p_we) p <= p_in;
    end
  end
endmodule

module systolic_ctrl #(
  parameter int DW       = 16,
  parameter int LANES    = 16,
  parameter int AW       = 8,
  parameter int WD_SLACK = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [5:0]          matrix_N,
  input  logic [AW-1:0]       a_base,
  input  logic [AW-1:0]       b_base,
  input  logic [AW-1:0]       p_base,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                rd_en,
  output logic [AW-1:0]       rd_addr,
  input  logic [DW-1:0]       rd_data,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [DW-1:0]       wr_data,
  output logic                arr_clr,
  output logic                arr_en,
  output logic [5:0]          arr_N,
  output logic [LANES*DW-1:0] a_vec,
  output logic [LANES*DW-1:0] b_vec,
  input  logic [LANES*DW-1:0] p_vec,
  input  logic                arr_ready
);
  localparam int LW = $clog2(LANES);

  typedef enum logic [2:0] {IDLE, LOAD, LOAD_WAIT, CLEAR, RUN, STORE, FIN} state_t;

  state_t                    state;
  logic [AW-1:0]             a_q, b_q, p_q;
  logic [6:0]                cnt;
  logic [7:0]                run_cnt;
  logic                      cap_vld, cap_b;
  logic [LW-1:0]             cap_lane;
  logic [LANES-1:0][DW-1:0]  a_lane, b_lane, p_lane;

  logic          n_ok, accept_ok, p_we;
  logic [6:0]    n7, nxt, off, ld_lane;
  logic          ld_b, nb;
  logic [AW-1:0] nxt_addr;
  logic [7:0]    run_lim;

  assign n7        = 7'(arr_N);
  assign n_ok      = (matrix_N != 6'd0) && (matrix_N <= 6'(LANES));
  assign accept_ok = (state == IDLE) && start && n_ok;
  assign p_we      = (state == RUN) && arr_ready;
  assign run_lim   = {1'b0, arr_N, 1'b0} + 8'(2 + WD_SLACK);

  // Issue index cnt maps to A lanes first, then B lanes; lane of the
  // current issue is remembered so its data lands one cycle later.
  always_comb begin
    nxt      = cnt + 7'd1;
    ld_b     = (cnt >= n7);
    ld_lane  = ld_b ? (cnt - n7) : cnt;
    nb       = (nxt >= n7);
    off      = nb ? (nxt - n7) : nxt;
    nxt_addr = (nb ? b_q : a_q) + AW'(off);
  end

  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      systolic_ctrl_lane #(.DW(DW)) u_lane (
        .clk   (clk),
        .reset (reset),
        .clr   (accept_ok),
        .a_we  (cap_vld && !cap_b && (cap_lane == LW'(k))),
        .b_we  (cap_vld &&  cap_b && (cap_lane == LW'(k))),
        .p_we  (p_we),
        .d     (rd_data),
        .p_in  (p_vec[k*DW +: DW]),
        .a     (a_lane[k]),
        .b     (b_lane[k]),
        .p     (p_lane[k])
      );
    end
  endgenerate

  assign a_vec = a_lane;
  assign b_vec = b_lane;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      arr_clr  <= 1'b1;
      arr_en   <= 1'b0;
      arr_N    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      cnt      <= '0;
      run_cnt  <= '0;
      cap_vld  <= 1'b0;
      cap_b    <= 1'b0;
      cap_lane <= '0;
    end else begin
      done     <= 1'b0;
      arr_clr  <= 1'b0;
      cap_vld  <= rd_en;
      cap_b    <= ld_b;
      cap_lane <= ld_lane[LW-1:0];
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (!n_ok) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            err     <= 1'b0;
            arr_N   <= matrix_N;
            a_q     <= a_base;
            b_q     <= b_base;
            p_q     <= p_base;
            rd_en   <= 1'b1;
            rd_addr <= a_base;
            cnt     <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (nxt == {arr_N, 1'b0}) begin
            rd_en <= 1'b0;
            state <= LOAD_WAIT;
          end else begin
            cnt     <= nxt;
            rd_addr <= nxt_addr;
          end
        end
        LOAD_WAIT: begin
          arr_clr <= 1'b1;
          state   <= CLEAR;
        end
        CLEAR: begin
          arr_en  <= 1'b1;
          run_cnt <= '0;
          state   <= RUN;
        end
        RUN: begin
          // A ready seen on the last allowed cycle still counts as success.
          if (arr_ready) begin
            arr_en  <= 1'b0;
            wr_en   <= 1'b1;
            wr_addr <= p_q;
            wr_data <= p_vec[DW-1:0];
            cnt     <= '0;
            state   <= STORE;
          end else if (run_cnt + 8'd1 == run_lim) begin
            arr_en <= 1'b0;
            err    <= 1'b1;
            done   <= 1'b1;
            state  <= FIN;
          end else begin
            run_cnt <= run_cnt + 8'd1;
          end
        end
        STORE: begin
          if (nxt == n7) begin
            wr_en <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            cnt     <= nxt;
            wr_addr <= p_q + AW'(nxt);
            wr_data <= p_lane[nxt[LW-1:0]];
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: directed and random jobs against a
// behavioural scratchpad/array model.
module tb_systolic_ctrl;
  localparam int DW = 16, LANES = 16, AW = 8, WD_SLACK = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [5:0]          matrix_N;
  logic [AW-1:0]       a_base, b_base, p_base;
  logic                busy, done, err;
  logic                rd_en, wr_en;
  logic [AW-1:0]       rd_addr, wr_addr;
  logic [DW-1:0]       rd_data, wr_data;
  logic                arr_clr, arr_en;
  logic [5:0]          arr_N;
  logic [LANES*DW-1:0] a_vec, b_vec, p_vec;
  logic                arr_ready;

  int passes = 0, total = 0, fails = 0;
  logic [DW-1:0] mem [256];

  systolic_ctrl #(.DW(DW), .LANES(LANES), .AW(AW), .WD_SLACK(WD_SLACK)) dut (
    .clk(clk), .reset(reset), .start(start), .matrix_N(matrix_N),
    .a_base(a_base), .b_base(b_base), .p_base(p_base),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .arr_clr(arr_clr), .arr_en(arr_en), .arr_N(arr_N),
    .a_vec(a_vec), .b_vec(b_vec), .p_vec(p_vec), .arr_ready(arr_ready)
  );

  always #5 clk = ~clk;

  // Scratchpad: data only valid the cycle after a read strobe, noise otherwise.
  always @(posedge clk)
    rd_data <= rd_en ? mem[rd_addr] : DW'($urandom);

  task automatic chk(input string tag, input logic [LANES*DW-1:0] obs, input logic [LANES*DW-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: start pulse, 1: start held through the job, 2: start toggles randomly while busy
  task automatic run_job(input int n, input logic [AW-1:0] ab, bb, pb, input int r, input int mode);
    logic [AW-1:0] got_rd[$], got_wa[$];
    logic [DW-1:0] got_wd[$];
    logic [LANES*DW-1:0] exp_a, exp_b;
    int cyc, clr_cnt, en_cnt, both, clr_en, busy_lo, lim, exp_lat, ndone;
    bit valid, got_done, wd;
    valid = (n >= 1 && n <= LANES);
    lim   = 2*n + 2 + WD_SLACK;
    wd    = valid && (r <= 0 || r > lim);
    for (int k = 0; k < LANES; k++) p_vec[k*DW +: DW] = DW'($urandom);
    exp_a = '0; exp_b = '0;
    for (int k = 0; k < n && valid; k++) begin
      exp_a[k*DW +: DW] = mem[AW'(ab + AW'(k))];
      exp_b[k*DW +: DW] = mem[AW'(bb + AW'(k))];
    end
    start = 1'b1; matrix_N = 6'(n); a_base = ab; b_base = bb; p_base = pb; arr_ready = 1'b0;
    cyc = 1; clr_cnt = 0; en_cnt = 0; both = 0; clr_en = 0; busy_lo = 0; got_done = 0;
    @(posedge clk);
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (mode == 0) start = 1'b0;
      else if (mode == 2) start = 1'($urandom_range(0, 1));
      if (rd_en) got_rd.push_back(rd_addr);
      if (wr_en) begin got_wa.push_back(wr_addr); got_wd.push_back(wr_data); end
      if (rd_en && wr_en) both++;
      if (arr_clr) begin clr_cnt++; if (arr_en) clr_en++; end
      if (arr_en) en_cnt++;
      if (!busy) busy_lo++;
      arr_ready = arr_en && (r > 0) && (en_cnt == r);
      if (done) begin got_done = 1; start = 1'b0; break; end
    end
    chk("done_seen", got_done, 1);
    if (!valid)  exp_lat = 2;
    else if (wd) exp_lat = 2*n + lim + 4;
    else         exp_lat = 3*n + r + 4;
    chk("latency", cyc, exp_lat);
    chk("err", err, (!valid || wd));
    chk("busy_held", busy_lo, 0);
    chk("rd_wr_excl", both, 0);
    chk("rd_count", got_rd.size(), valid ? 2*n : 0);
    for (int k = 0; k < got_rd.size() && k < 2*n; k++)
      chk("rd_addr", got_rd[k], (k < n) ? AW'(ab + AW'(k)) : AW'(bb + AW'(k - n)));
    chk("wr_count", got_wa.size(), (valid && !wd) ? n : 0);
    for (int k = 0; k < got_wa.size() && k < n; k++) begin
      chk("wr_addr", got_wa[k], AW'(pb + AW'(k)));
      chk("wr_data", got_wd[k], p_vec[k*DW +: DW]);
    end
    chk("clr_pulses", clr_cnt, valid ? 1 : 0);
    chk("clr_vs_en", clr_en, 0);
    chk("en_cycles", en_cnt, !valid ? 0 : (wd ? lim : r));
    if (valid) begin
      chk("a_vec", a_vec, exp_a);
      chk("b_vec", b_vec, exp_b);
      chk("arr_N", arr_N, n);
    end
    ndone = 0; busy_lo = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) busy_lo++;
    end
    chk("idle_done", ndone, 0);
    chk("idle_busy", busy_lo, 0);
  endtask

  initial begin
    int n, r, ndone;
    reset = 1'b1; start = 1'b0; matrix_N = '0; a_base = '0; b_base = '0; p_base = '0;
    p_vec = '0; arr_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    for (int k = 0; k < 4; k++) begin
      mem[8'h10 + k] = DW'(k + 1);
      mem[8'h20 + k] = DW'(k + 5);
    end
    repeat (3) @(negedge clk);
    chk("rst_arr_clr", arr_clr, 1);
    chk("rst_outs", {busy, done, err, rd_en, wr_en, arr_en, arr_N, rd_addr, wr_addr, wr_data}, 0);
    chk("rst_vec", {a_vec, b_vec}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("clr_fall", arr_clr, 0);

    run_job(4, 8'h10, 8'h20, 8'h30, 2*4 + 3, 0);
    run_job(0, 8'h10, 8'h20, 8'h30, 11, 0);
    run_job(17, 8'h10, 8'h20, 8'h30, 11, 0);
    run_job(3, 8'h55, 8'h66, 8'h77, 9, 0);
    run_job(16, 8'hF8, 8'h40, 8'h80, 2*16 + 3, 0);
    run_job(2, 8'h01, 8'h02, 8'h03, 0, 0);
    run_job(5, 8'hA0, 8'hB0, 8'hC0, 13, 1);
    run_job(6, 8'h11, 8'h22, 8'hFE, 15, 2);
    run_job(3, 8'h30, 8'h40, 8'h50, 2*3 + 2 + WD_SLACK, 0);
    for (int i = 0; i < 5; i++) begin
      n = $urandom_range(1, LANES);
      r = $urandom_range(1, 2*n + 2 + WD_SLACK);
      run_job(n, AW'($urandom), AW'($urandom), AW'($urandom), r, 0);
    end

    // Reset in the middle of RUN aborts the job silently.
    start = 1'b1; matrix_N = 6'd3; a_base = 8'h10; b_base = 8'h20; p_base = 8'h30;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !arr_en; i++) @(negedge clk);
    chk("mid_run", arr_en, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_clr", arr_clr, 1);
    chk("mid_rst_outs", {busy, done, err, rd_en, wr_en, arr_en, arr_N}, 0);
    chk("mid_rst_vec", {a_vec, b_vec}, 0);
    ndone = 0;
    repeat (2) begin @(negedge clk); if (done) ndone++; end
    reset = 1'b0;
    @(negedge clk);
    if (done) ndone++;
    chk("mid_rst_nodone", ndone, 0);
    chk("mid_rst_clr_fall", arr_clr, 0);
    run_job(4, 8'h10, 8'h20, 8'h30, 11, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Job sequencer for the 16-lane systolic array. On a host start it fetches the A and B operand vectors from the shared scratchpad and clears the array. It then enables the array until the array reports ready and writes the N result lanes back to the scratchpad. It sits between the host command interface, the scratchpad word port and one systolic array instance.

Parameters:
DW, 16, data word width (array lane width)
LANES, 16, array lane count; N legal range 1..LANES
AW, 8, scratchpad word-address width
WD_SLACK, 8, watchdog margin added to expected run length

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  job request, sampled only in IDLE
matrix_N  in  6  job size, latched on accepted start
a_base  in  AW  scratchpad address of A word 0
b_base  in  AW  scratchpad address of B word 0
p_base  in  AW  scratchpad address of result word 0
busy  out  1  high from accepted start until DONE exits
done  out  1  one-cycle pulse at job end
err  out  1  sticky job error, cleared on next accepted start
rd_en  out  1  scratchpad read strobe
rd_addr  out  AW  read address
rd_data  in  DW  read data, valid exactly 1 cycle after rd_en
wr_en  out  1  scratchpad write strobe
wr_addr  out  AW  write address
wr_data  out  DW  write data
arr_clr  out  1  drives the array reset
arr_en  out  1  drives the array enable
arr_N  out  6  latched N to the array
a_vec  out  LANES*DW  A lanes, lane k at bits [k*DW +: DW]
b_vec  out  LANES*DW  B lanes, same packing
p_vec  in  LANES*DW  array results, same packing
arr_ready  in  1  array completion flag

Behaviour:
- Reset values: all outputs 0, except arr_clr=1. The FSM enters IDLE and a_vec, b_vec and internal counters clear. arr_clr falls on the first clock after reset deasserts. Reset mid-job aborts with no done pulse.
- States: IDLE, LOAD, LOAD_WAIT, CLEAR, RUN, STORE, FIN.
- IDLE, start=1:
  - N=0 or N>LANES: latch err=1 and go to FIN. No memory access.
  - Otherwise latch N and the three bases, clear err, zero a_vec and b_vec, set busy, go to LOAD.
- start while busy is ignored.
- LOAD: 2N consecutive cycles with rd_en=1.
  - Issue k=0..N-1: rd_addr=a_base+k.
  - Issue N+k: rd_addr=b_base+k.
  - Address addition wraps mod 2^AW.
  - Data returned 1 cycle later goes to A lane k or B lane k respectively. Lanes N..LANES-1 stay 0.
- LOAD_WAIT: 1 cycle, rd_en=0. Captures the final B word.
- CLEAR: arr_clr=1 for exactly 1 cycle, arr_en=0.
- RUN: arr_en=1, and a run counter increments each cycle.
  - arr_ready=1 sampled: arr_en drops next cycle, p_vec is captured into a result register, go to STORE.
  - Counter reaches 2N+2+WD_SLACK without ready: err=1, arr_en=0, go to FIN (no writes).
- STORE: N consecutive cycles with wr_en=1, wr_addr=p_base+k, wr_data=captured lane k, k=0..N-1.
- FIN: done=1 for 1 cycle, busy=0 next cycle, return to IDLE. err holds until the next accepted start.
- a_vec, b_vec and arr_N stay stable from LOAD_WAIT exit until FIN.
- rd_en and wr_en are never high in the same cycle.
- Nominal latency: start to done = 1 + 2N + 1 + 1 + R + N + 1 cycles, where R is the RUN cycle count (2N+3 for a conforming array).

Test Plan:
- N=4, a_base=0x10, b_base=0x20, p_base=0x30, memory A=[1,2,3,4], B=[5,6,7,8] -> reads 0x10-0x13 then 0x20-0x23; arr_clr pulses once; arr_en runs until ready; writes 0x30-0x33 equal captured p_vec lanes 0-3; one done pulse; err=0; a_vec lanes 4-15 =0.
- start with matrix_N=0, then matrix_N=17 -> no rd_en/wr_en, done next-but-one cycle, err=1 both times; next valid start clears err.
- N=16, a_base=0xF8 -> read addresses wrap 0xF8..0xFF,0x00..0x07; all 16 lanes loaded; 16 writes.
- arr_ready tied 0, N=2 -> arr_en high for 2*2+2+8=14 cycles, err=1, no wr_en, done pulses.
- start held high through a whole job -> exactly one job per IDLE visit; start pulses during busy are ignored.
- reset asserted mid-RUN -> all outputs 0 and arr_clr=1 immediately; no done pulse; a new start after release runs a full clean job.
